touch_point_mapper: RTL

//  Downstream of the touchpad SPI controller. Takes averaged raw x/y/z (12b) each time a full
//  x->y->z group completes. Clamps and scales raw x/y to screen pixels; debounces press/release on z.

---
 rtl/touch_pkg.sv | 42 ++++
 rtl/touch_axis_scale.sv | 48 ++++
 rtl/touch_point_mapper.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/touch_pkg.sv
// Shared constants, calibration defaults and FSM state type for the touch point mapper.
package touch_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int PX_W     = 9;
    localparam int PY_W     = 8;
    localparam int RAW_W    = 12;
    localparam int OFS_W    = 11;
    localparam int SCALE_W  = 17;
    localparam int FRAC_W   = 16;
    localparam int CNT_W    = 3;

    localparam logic [RAW_W-1:0]   X_MIN_DEF    = 12'h090;
    localparam logic [RAW_W-1:0]   X_SPAN_DEF   = 12'h6B5;
    localparam logic [RAW_W-1:0]   Y_MIN_DEF    = 12'h060;
    localparam logic [RAW_W-1:0]   Y_SPAN_DEF   = 12'h690;
    localparam logic [SCALE_W-1:0] X_SCALE_DEF  = 17'd12207;
    localparam logic [SCALE_W-1:0] Y_SCALE_DEF  = 17'd9356;
    localparam logic [RAW_W-1:0]   Z_THRESH_DEF = 12'h100;
    localparam int                 DEBOUNCE_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS_P = 2'd1,
        ST_TOUCH   = 2'd2,
        ST_REL_P   = 2'd3
    } touch_state_e;

    // Moves cur a quarter of the way toward tgt; floor rounding keeps the result between the two.
    function automatic logic [PX_W-1:0] smooth_step(input logic [PX_W-1:0] cur,
                                                    input logic [PX_W-1:0] tgt);
        logic signed [PX_W:0] diff;
        logic signed [PX_W:0] step;
        logic signed [PX_W:0] sum;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        step = diff >>> 2;
        sum  = $signed({1'b0, cur}) + step;
        return sum[PX_W-1:0];
    endfunction

endpackage

// File: rtl/touch_axis_scale.sv
// One axis of the mapper: clamp and offset raw value (registered), then Q0.16 multiply-shift.
module touch_axis_scale
    import touch_pkg::*;
#(
    parameter logic [RAW_W-1:0]   MIN   = X_MIN_DEF,
    parameter logic [RAW_W-1:0]   SPAN  = X_SPAN_DEF,
    parameter logic [SCALE_W-1:0] SCALE = X_SCALE_DEF,
    parameter int                 OUT_W = PX_W
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic             load,
    input  logic [RAW_W-1:0] raw,
    output logic [OUT_W-1:0] pix
);

    localparam logic [RAW_W-1:0] MAX = MIN + SPAN;

    logic [RAW_W-1:0]         clamped;
    logic [RAW_W-1:0]         offset_full;
    logic [OFS_W-1:0]         offset_q;
    logic [OFS_W+SCALE_W-1:0] product;
    logic                     unused_bits;

    always_comb begin
        clamped = raw;
        if (raw < MIN)
            clamped = MIN;
        else if (raw > MAX)
            clamped = MAX;
        offset_full = clamped - MIN;
    end

    always_ff @(posedge cclk) begin
        if (rst)
            offset_q <= '0;
        else if (load)
            offset_q <= offset_full[OFS_W-1:0];
    end

    // The scale factors are floored so a full-span offset lands on the last pixel without saturation.
    assign product = {{SCALE_W{1'b0}}, offset_q} * {{OFS_W{1'b0}}, SCALE};
    assign pix     = product[FRAC_W +: OUT_W];

    assign unused_bits = ^{product[FRAC_W-1:0], product[OFS_W+SCALE_W-1:FRAC_W+OUT_W],
                           offset_full[RAW_W-1:OFS_W]};

endmodule

// File: rtl/touch_point_mapper.sv
// Maps averaged raw touch samples to screen pixels with debounced press/release tracking.
// Build option: define TOUCH_SMOOTH_EN to low-pass filter the point while touching.
module touch_point_mapper
    import touch_pkg::*;
#(
    parameter logic [RAW_W-1:0]   X_MIN    = X_MIN_DEF,
    parameter logic [RAW_W-1:0]   X_SPAN   = X_SPAN_DEF,
    parameter logic [RAW_W-1:0]   Y_MIN    = Y_MIN_DEF,
    parameter logic [RAW_W-1:0]   Y_SPAN   = Y_SPAN_DEF,
    parameter logic [SCALE_W-1:0] X_SCALE  = X_SCALE_DEF,
    parameter logic [SCALE_W-1:0] Y_SCALE  = Y_SCALE_DEF,
    parameter logic [RAW_W-1:0]   Z_THRESH = Z_THRESH_DEF,
    parameter int                 DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [RAW_W-1:0] raw_x,
    input  logic [RAW_W-1:0] raw_y,
    input  logic [RAW_W-1:0] raw_z,
    output logic [PX_W-1:0]  px,
    output logic [PY_W-1:0]  py,
    output logic             point_valid,
    output logic             touch_active,
    output logic             press_pulse,
    output logic             release_pulse
);

    localparam logic [CNT_W-1:0] DEB = DEBOUNCE[CNT_W-1:0];

    touch_state_e     fsm_state;
    touch_state_e     state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             valid_s1;
    logic             pressed_s1;
    logic [PX_W-1:0]  pix_x;
    logic [PY_W-1:0]  pix_y;
    logic [PX_W-1:0]  upd_x;
    logic [PY_W-1:0]  upd_y;
    logic [PX_W-1:0]  px_n;
    logic [PY_W-1:0]  py_n;
    logic             pv_n;
    logic             active_n;
    logic             press_n;
    logic             release_n;

    touch_axis_scale #(.MIN(X_MIN), .SPAN(X_SPAN), .SCALE(X_SCALE), .OUT_W(PX_W)) u_axis_x (
        .cclk (cclk),
        .rst  (rst),
        .load (sample_valid),
        .raw  (raw_x),
        .pix  (pix_x)
    );

    touch_axis_scale #(.MIN(Y_MIN), .SPAN(Y_SPAN), .SCALE(Y_SCALE), .OUT_W(PY_W)) u_axis_y (
        .cclk (cclk),
        .rst  (rst),
        .load (sample_valid),
        .raw  (raw_y),
        .pix  (pix_y)
    );

`ifdef TOUCH_SMOOTH_EN
    logic [PX_W-1:0] smooth_y;
    logic            unused_smooth;
    assign smooth_y      = smooth_step({1'b0, py}, {1'b0, pix_y});
    assign upd_x         = smooth_step(px, pix_x);
    assign upd_y         = smooth_y[PY_W-1:0];
    assign unused_smooth = smooth_y[PX_W-1];
`else
    assign upd_x = pix_x;
    assign upd_y = pix_y;
`endif

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n   = fsm_state;
        cnt_n     = cnt;
        px_n      = px;
        py_n      = py;
        pv_n      = 1'b0;
        active_n  = touch_active;
        press_n   = 1'b0;
        release_n = 1'b0;
        if (valid_s1) begin
            case (fsm_state)
                ST_IDLE: begin
                    if (pressed_s1) begin
                        if (DEBOUNCE == 1) begin
                            state_n  = ST_TOUCH;
                            cnt_n    = '0;
                            press_n  = 1'b1;
                            active_n = 1'b1;
                            px_n     = pix_x;
                            py_n     = pix_y;
                            pv_n     = 1'b1;
                        end else begin
                            state_n = ST_PRESS_P;
                            cnt_n   = 1;
                        end
                    end
                end
                ST_PRESS_P: begin
                    if (!pressed_s1) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt_inc >= DEB) begin
                        // Entry loads the raw point directly; smoothing only applies afterwards.
                        state_n  = ST_TOUCH;
                        cnt_n    = '0;
                        press_n  = 1'b1;
                        active_n = 1'b1;
                        px_n     = pix_x;
                        py_n     = pix_y;
                        pv_n     = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                ST_TOUCH: begin
                    if (pressed_s1) begin
                        px_n = upd_x;
                        py_n = upd_y;
                        pv_n = 1'b1;
                    end else if (DEBOUNCE == 1) begin
                        state_n   = ST_IDLE;
                        cnt_n     = '0;
                        release_n = 1'b1;
                        active_n  = 1'b0;
                    end else begin
                        state_n = ST_REL_P;
                        cnt_n   = 1;
                    end
                end
                ST_REL_P: begin
                    if (pressed_s1) begin
                        state_n = ST_TOUCH;
                        cnt_n   = '0;
                        px_n    = upd_x;
                        py_n    = upd_y;
                        pv_n    = 1'b1;
                    end else if (cnt_inc >= DEB) begin
                        state_n   = ST_IDLE;
                        cnt_n     = '0;
                        release_n = 1'b1;
                        active_n  = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            valid_s1      <= 1'b0;
            pressed_s1    <= 1'b0;
            fsm_state     <= ST_IDLE;
            cnt           <= '0;
            px            <= '0;
            py            <= '0;
            point_valid   <= 1'b0;
            touch_active  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            valid_s1      <= sample_valid;
            pressed_s1    <= (raw_z > Z_THRESH);
            fsm_state     <= state_n;
            cnt           <= cnt_n;
            px            <= px_n;
            py            <= py_n;
            point_valid   <= pv_n;
            touch_active  <= active_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

endmodule
